// File: rtl/param_wave_gen.sv
// Parameterised waveform generator: divided tick drives a phase accumulator
// shaped into sawtooth, triangle, square or reverse sawtooth samples.
module param_wave_gen #(
  parameter int CNT_W = 10,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic [CNT_W-1:0] SW,
  input  logic [1:0]       mode,
  input  logic             sel,
  input  logic             start,
  output logic [OUT_W-1:0] out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);
  localparam logic [OUT_W-1:0] P_ONE = OUT_W'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_div;
  logic [CNT_W-1:0] r_cnt;
  logic [OUT_W-1:0] r_phase;
  logic [1:0]       r_mode;
  logic             r_sel;
  logic             r_busy;
  logic             r_done;

  logic             w_tick;
  logic             w_last;
  logic [OUT_W-1:0] w_dbl;
  logic [OUT_W-1:0] w_wave;

  // Compared against the live divisor so a reload bites at once.
  assign w_tick = (r_cnt == r_div);
  assign w_last = &r_phase;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_div   <= '0;
      r_cnt   <= '0;
      r_phase <= '0;
      r_mode  <= 2'b00;
      r_sel   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      if (init) r_div <= SW;
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mode  <= mode;
            r_sel   <= sel;
            r_phase <= '0;
            r_cnt   <= '0;
            r_state <= RUN;
            r_busy  <= 1'b1;
          end
        end
        RUN: begin
          if (w_tick) begin
            r_cnt   <= '0;
            r_phase <= r_phase + P_ONE;
          end else begin
            r_cnt   <= r_cnt + C_ONE;
          end
          if (r_sel && w_tick && w_last) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if (!r_sel && start) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign w_dbl = {r_phase[OUT_W-2:0], 1'b0};

  always_comb begin
    w_wave = '0;
    case (r_mode)
      2'b00: w_wave = r_phase;
      2'b01: w_wave = r_phase[OUT_W-1] ? ~w_dbl : w_dbl;
      2'b10: w_wave = {OUT_W{r_phase[OUT_W-1]}};
      2'b11: w_wave = ~r_phase;
      default: w_wave = '0;
    endcase
  end

  assign out  = (r_state == RUN) ? w_wave : '0;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_param_wave_gen.sv
// Directed and randomised checks of param_wave_gen against an
// arithmetic reference model of the waveform generator.
module tb_param_wave_gen;

  localparam int CNT_W = 10;
  localparam int OUT_W = 8;
  localparam int PMAX  = (1 << OUT_W) - 1;
  localparam int HALF  = 1 << (OUT_W - 1);
  localparam int CMOD  = 1 << CNT_W;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             init = 1'b0;
  logic [CNT_W-1:0] SW = '0;
  logic [1:0]       mode = 2'b00;
  logic             sel = 1'b0;
  logic             start = 1'b0;
  logic [OUT_W-1:0] out;
  logic             busy;
  logic             done;

  int n_checks = 0;
  int n_err    = 0;

  // model: 0 idle, 1 running, 2 finished
  int m_st   = 0;
  int m_div  = 0;
  int m_cnt  = 0;
  int m_ph   = 0;
  int m_mode = 0;
  int m_sel  = 0;
  int n_done = 0;

  param_wave_gen #(.CNT_W(CNT_W), .OUT_W(OUT_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .init (init),
    .SW   (SW),
    .mode (mode),
    .sel  (sel),
    .start(start),
    .out  (out),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_out();
    int v;
    if (m_st != 1) return 0;
    case (m_mode)
      0: v = m_ph;
      1: v = (m_ph < HALF) ? 2 * m_ph : PMAX - 2 * (m_ph - HALF);
      2: v = (m_ph >= HALF) ? PMAX : 0;
      default: v = PMAX - m_ph;
    endcase
    return v;
  endfunction

  task automatic model_step();
    int ndiv;
    bit tick;
    if (rst) begin
      m_st = 0; m_div = 0; m_cnt = 0; m_ph = 0;
      m_mode = 0; m_sel = 0;
      return;
    end
    ndiv = init ? int'(SW) : m_div;
    if (m_st == 0) begin
      if (start) begin
        m_mode = int'(mode); m_sel = int'(sel);
        m_ph = 0; m_cnt = 0; m_st = 1;
      end
    end else if (m_st == 1) begin
      tick = (m_cnt == m_div);
      if (tick) begin
        if (m_sel == 1 && m_ph == PMAX) m_st = 2;
        m_ph = (m_ph + 1) % (PMAX + 1);
        m_cnt = 0;
      end else begin
        m_cnt = (m_cnt + 1) % CMOD;
      end
      if (m_sel == 0 && start) m_st = 0;
    end else begin
      m_st = 0;
    end
    m_div = ndiv;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("out", 32'(out), 32'(exp_out()));
    chk("busy", 32'(busy), 32'(m_st == 1));
    chk("done", 32'(done), 32'(m_st == 2));
    if (done === 1'b1) n_done++;
  endtask

  initial begin
    int zeros, ones, d0;

    // reset
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);

    // one-shot sawtooth, tick every cycle
    SW = 0; init = 1'b1;
    cyc();
    init = 1'b0;
    mode = 2'b00; sel = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 256; i++) begin
      chk("saw_seq", 32'(out), 32'(i));
      cyc();
    end
    chk("saw_done", 32'(done), 32'd1);
    cyc();
    chk("saw_idle_out", 32'(out), 32'd0);
    chk("saw_idle_busy", 32'(busy), 32'd0);

    // one-shot square, divide by 4
    SW = 3; init = 1'b1;
    cyc();
    init = 1'b0;
    mode = 2'b10; sel = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    zeros = 0; ones = 0;
    for (int i = 0; i < 1024; i++) begin
      if (i < 512 && out === '0) zeros++;
      if (i >= 512 && out === '1) ones++;
      cyc();
    end
    chk("sq_zeros", 32'(zeros), 32'd512);
    chk("sq_ones", 32'(ones), 32'd512);
    chk("sq_done", 32'(done), 32'd1);
    cyc();

    // continuous triangle, stopped by a second start
    SW = 0; init = 1'b1;
    cyc();
    init = 1'b0;
    mode = 2'b01; sel = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 520; i++) begin
      if (i == 1)   chk("tri_1", 32'(out), 32'd2);
      if (i == 127) chk("tri_127", 32'(out), 32'd254);
      if (i == 128) chk("tri_128", 32'(out), 32'd255);
      if (i == 129) chk("tri_129", 32'(out), 32'd253);
      if (i == 255) chk("tri_255", 32'(out), 32'd1);
      if (i == 257) chk("tri_wrap", 32'(out), 32'd2);
      cyc();
    end
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("tri_stop_busy", 32'(busy), 32'd0);
    chk("tri_stop_out", 32'(out), 32'd0);

    // divisor reload and mode change mid-run
    SW = 9; init = 1'b1;
    cyc();
    init = 1'b0;
    mode = 2'b00; sel = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (50) cyc();
    chk("reload_ph5", 32'(out), 32'd5);
    SW = 1; init = 1'b1; mode = 2'b11;
    cyc();
    init = 1'b0;
    chk("reload_hold", 32'(out), 32'd5);
    cyc();
    chk("reload_tick", 32'(out), 32'd6);
    repeat (20) cyc();
    chk("reload_rate", 32'(out), 32'd16);
    start = 1'b1;
    cyc();
    start = 1'b0;

    // reset aborts a one-shot run and beats start
    SW = 0; init = 1'b1;
    cyc();
    init = 1'b0;
    mode = 2'b00; sel = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (100) cyc();
    chk("abort_ph", 32'(out), 32'd100);
    d0 = n_done;
    rst = 1'b1; start = 1'b1;
    cyc();
    rst = 1'b0; start = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_out", 32'(out), 32'd0);
    repeat (300) cyc();
    chk("abort_nodone", 32'(n_done - d0), 32'd0);
    chk("abort_idle", 32'(busy), 32'd0);

    // init and start together
    SW = 1; init = 1'b1; start = 1'b1; mode = 2'b00; sel = 1'b0;
    cyc();
    init = 1'b0; start = 1'b0;
    chk("same_c0", 32'(out), 32'd0);
    cyc();
    chk("same_c1", 32'(out), 32'd0);
    cyc();
    chk("same_c2", 32'(out), 32'd1);
    start = 1'b1;
    cyc();
    start = 1'b0;

    // randomised traffic
    for (int i = 0; i < 6000; i++) begin
      rst   = ($urandom_range(0, 499) == 0);
      init  = ($urandom_range(0, 31) == 0);
      SW    = ($urandom_range(0, 7) == 0) ? CNT_W'($urandom)
                                          : CNT_W'($urandom_range(0, 2));
      mode  = 2'($urandom);
      sel   = 1'($urandom);
      start = ($urandom_range(0, 63) == 0);
      cyc();
    end
    rst = 1'b0; init = 1'b0; start = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
